boctet_ctrl: RTL

BOCTET_CTRL -- requirements
Module: boctet_ctrl

---
 rtl/boctet_pkg.sv | 20 ++
 rtl/boctet_credit_cnt.sv | 36 +++
 rtl/boctet_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/boctet_pkg.sv
// boctet_pkg: shared types and widths for the bOctet controller.
//   state_t : controller FSM states
//   TILE_W / VEC_W / PERF_W : tile counter, vector counter, perf counter widths
//   CRED_W  : credit counter width (covers CREDITS up to 15)
package boctet_pkg;

  localparam int unsigned TILE_W = 8;
  localparam int unsigned VEC_W  = 12;
  localparam int unsigned PERF_W = 32;
  localparam int unsigned CRED_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    STREAM,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/boctet_credit_cnt.sv
// boctet_credit_cnt: downstream result-slot credit counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (reloads CREDITS)
//   take      : one slot consumed this cycle (an issue)
//   give      : one slot returned this cycle (credit_ret)
//   avail_c   : at least one credit held (combinational decode of the counter)
module boctet_credit_cnt
  import boctet_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  input  logic give,
  output logic avail_c
);

  localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(CREDITS);

  logic [CRED_W-1:0] count;

  // Simultaneous take/give cancel; returns beyond MAX_CRED are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= MAX_CRED;
    end else if (take && !give) begin
      count <= count - CRED_W'(1);
    end else if (give && !take && (count != MAX_CRED)) begin
      count <= count + CRED_W'(1);
    end
  end

  assign avail_c = (count != '0);

endmodule

// File: rtl/boctet_ctrl.sv
// boctet_ctrl: job sequencer for a bOctet tile engine.
// Loads one weight tile, streams cfg_num_vecs activation/psum pairs through a
// PIPE_LAT-deep result pipeline under credit flow control, drains, and repeats
// for cfg_num_tiles tiles.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   start, cfg_num_tiles/vecs      : job start pulse and job size (sampled in IDLE)
//   busy, done                     : job active, one-cycle completion pulse
//   w_valid/w_ready                : weight tile handshake
//   a_valid/a_ready, p_valid/p_ready : activation and psum handshakes (joint)
//   weight/activation/psum_update  : bOctet register enables
//   res_valid, res_last            : result strobe and final-result flag
//   credit_ret                     : downstream slot return pulse
//   perf_busy_cyc, perf_stall_cyc  : only when BOCTET_CTRL_PERF_EN is defined
// Handshake and strobe outputs are same-cycle decodes of state and inputs.
module boctet_ctrl
  import boctet_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned CREDITS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [VEC_W-1:0]  cfg_num_vecs,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              a_valid,
  input  logic              p_valid,
  output logic              a_ready,
  output logic              p_ready,
  output logic              weight_update,
  output logic              activation_update,
  output logic              psum_update,
  output logic              res_valid,
  output logic              res_last,
  input  logic              credit_ret
`ifdef BOCTET_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_busy_cyc,
  output logic [PERF_W-1:0] perf_stall_cyc
`endif
);

  state_t state_q, state_d;

  logic [TILE_W-1:0]   num_tiles_q, tile_cnt_q;
  logic [VEC_W-1:0]    num_vecs_q, vec_cnt_q;
  logic [PIPE_LAT-1:0] vld_sr_q, last_sr_q;

  logic job_start, issue, tile_adv, credit_avail, last_vec, last_tile, sr_empty;

  assign job_start = (state_q == IDLE) && start;
  assign last_vec  = (vec_cnt_q == num_vecs_q - VEC_W'(1));
  assign last_tile = (tile_cnt_q == num_tiles_q - TILE_W'(1));
  assign sr_empty  = (vld_sr_q == '0);

  boctet_credit_cnt #(
    .CREDITS(CREDITS)
  ) u_credit (
    .clk    (clk),
    .rst    (rst),
    .take   (issue),
    .give   (credit_ret),
    .avail_c(credit_avail)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/strobe decode.
  always_comb begin
    state_d           = state_q;
    busy              = (state_q != IDLE);
    done              = 1'b0;
    w_ready           = 1'b0;
    weight_update     = 1'b0;
    a_ready           = 1'b0;
    p_ready           = 1'b0;
    activation_update = 1'b0;
    psum_update       = 1'b0;
    issue             = 1'b0;
    tile_adv          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ((cfg_num_tiles == '0) || (cfg_num_vecs == '0)) ? FIN : WLOAD;
        end
      end
      WLOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          weight_update = 1'b1;
          state_d       = STREAM;
        end
      end
      STREAM: begin
        // Activation and psum are accepted together or not at all.
        if (a_valid && p_valid && credit_avail) begin
          issue             = 1'b1;
          a_ready           = 1'b1;
          p_ready           = 1'b1;
          activation_update = 1'b1;
          psum_update       = 1'b1;
          if (last_vec) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Weights may only change once every in-flight result has emerged.
        if (sr_empty) begin
          if (last_tile) begin
            state_d = FIN;
          end else begin
            tile_adv = 1'b1;
            state_d  = WLOAD;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job configuration, tile/vector counters and the result pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_tiles_q <= '0;
      num_vecs_q  <= '0;
      tile_cnt_q  <= '0;
      vec_cnt_q   <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      if (job_start) begin
        num_tiles_q <= cfg_num_tiles;
        num_vecs_q  <= cfg_num_vecs;
        tile_cnt_q  <= '0;
        vec_cnt_q   <= '0;
      end else begin
        if (issue) begin
          vec_cnt_q <= last_vec ? '0 : vec_cnt_q + VEC_W'(1);
        end
        if (tile_adv) begin
          tile_cnt_q <= tile_cnt_q + TILE_W'(1);
        end
      end
      vld_sr_q  <= (vld_sr_q << 1) | PIPE_LAT'(issue);
      last_sr_q <= (last_sr_q << 1) | PIPE_LAT'(issue && last_vec && last_tile);
    end
  end

  assign res_valid = vld_sr_q[PIPE_LAT-1];
  assign res_last  = vld_sr_q[PIPE_LAT-1] & last_sr_q[PIPE_LAT-1];

`ifdef BOCTET_CTRL_PERF_EN
  // Busy cycles and STREAM cycles without an issue, cleared per job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (job_start) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state_q != IDLE) begin
        perf_busy_cyc <= perf_busy_cyc + PERF_W'(1);
      end
      if ((state_q == STREAM) && !issue) begin
        perf_stall_cyc <= perf_stall_cyc + PERF_W'(1);
      end
    end
  end
`endif

endmodule
